// File: rtl/fetch_if.sv
// Fetch-side bundle: redirect input, imem req/ack channel and
// the downstream instruction valid/ready handshake.
interface fetch_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic [31:0] pc_out;

  modport master (
    input  redirect_valid,
    input  redirect_pc,
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata,
    output inst_valid,
    input  inst_ready,
    output inst_out,
    output inst_pc,
    output pc_out
  );

  modport slave (
    output redirect_valid,
    output redirect_pc,
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata,
    input  inst_valid,
    output inst_ready,
    input  inst_out,
    input  inst_pc,
    input  pc_out
  );
endinterface

// File: rtl/fetch_ctrl.sv
// PC sequencer and single-outstanding instruction fetch with
// squash-on-redirect; at most one instruction every two cycles.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic     clk,
  input  logic     rst,
  fetch_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pend_q, pend_d;
  logic              squash_q, squash_d;
  logic              valid_q, valid_d;
  logic [31:0]       iout_q, iout_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;
  logic [ADDR_W-1:0] tgt;
  logic              ack;
  logic              redir;

  assign tgt   = {bus.redirect_pc[ADDR_W-1:2], 2'b00};
  assign ack   = bus.imem_ack;
  assign redir = bus.redirect_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      pend_q   <= '0;
      squash_q <= 1'b0;
      valid_q  <= 1'b0;
      iout_q   <= '0;
      ipc_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pend_q   <= pend_d;
      squash_q <= squash_d;
      valid_q  <= valid_d;
      iout_q   <= iout_d;
      ipc_q    <= ipc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pend_d   = pend_q;
    squash_d = squash_q;
    valid_d  = valid_q;
    iout_d   = iout_q;
    ipc_d    = ipc_q;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        // the address on the bus only moves once the access has been acked
        unique case (1'b1)
          ack && redir: begin
            pc_d     = tgt;
            squash_d = 1'b0;
          end
          ack && !redir && squash_q: begin
            pc_d     = pend_q;
            squash_d = 1'b0;
          end
          ack && !redir && !squash_q: begin
            iout_d  = bus.imem_rdata;
            ipc_d   = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + 32'd4;
            state_d = HOLD;
          end
          !ack && redir: begin
            pend_d   = tgt;
            squash_d = 1'b1;
          end
          default: ;
        endcase
      end
      HOLD: begin
        if (redir) begin
          valid_d = 1'b0;
          pc_d    = tgt;
          state_d = REQ;
        end else if (bus.inst_ready) begin
          valid_d = 1'b0;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.imem_req   = (state_q == REQ);
  assign bus.imem_addr  = pc_q;
  assign bus.inst_valid = valid_q;
  assign bus.inst_out   = iout_q;
  assign bus.inst_pc    = ipc_q;
  assign bus.pc_out     = pc_q;

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Sequences the program counter and the instruction-memory fetch for the core. Owns the PC register and issues one request at a time over a req/ack interface to instruction memory, which may have variable latency. Presents fetched instructions downstream through a valid/ready handshake. Accepts branch/jump redirects from execute, and squashes any fetch still in flight when a redirect arrives.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
ADDR_W, 32, PC/address width (only 32 is supported)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
redirect_valid  in  1  take redirect_pc as the next fetch address (execute's PCSrc)
redirect_pc  in  32  branch/jump target; bits[1:0] ignored, treated as 0
imem_req  out  1  fetch request to instruction memory
imem_addr  out  32  fetch address; stable while imem_req=1 and not yet acked
imem_ack  in  1  memory response valid; imem_rdata is valid in the same cycle
imem_rdata  in  32  fetched instruction word
inst_valid  out  1  inst_out/inst_pc hold a valid instruction
inst_ready  in  1  downstream accepts the instruction
inst_out  out  32  instruction word
inst_pc  out  32  address of inst_out
pc_out  out  32  current PC register (the next fetch address)

Behaviour:
- Reset (asynchronous):
  - pc=RESET_PC, state=IDLE.
  - imem_req=0, inst_valid=0, squash=0.
  - inst_out=0, inst_pc=0, pending_pc=0.
- All outputs are registered or decoded from state only. No combinational path from inputs to outputs.
- States: IDLE, REQ, HOLD.
- IDLE: imem_req=0. Goes to REQ on the next clock unconditionally. The first request is therefore visible in the 2nd cycle after reset release.
- REQ:
  - imem_req=1, imem_addr=pc.
  - A request completes on a clock edge where imem_ack=1. An ack in the first REQ cycle is legal, giving 1-cycle minimum latency.
  - Ack, squash=0, no redirect this cycle:
    - inst_out<=imem_rdata, inst_pc<=pc, inst_valid<=1.
    - pc<=pc+4 (mod 2^32; 0xFFFF_FFFC wraps to 0).
    - state<=HOLD.
  - No ack, redirect_valid=1: pending_pc<=redirect_pc, squash<=1, stay REQ.
    - imem_addr does not change until the ack.
    - Further redirects before the ack overwrite pending_pc; the latest one wins.
  - Ack with squash=1 and no redirect: discard rdata, pc<=pending_pc, squash<=0, stay REQ. The new address is presented on the next cycle.
  - Ack coincident with redirect_valid (any squash value): discard rdata, pc<=redirect_pc, squash<=0, stay REQ.
  - imem_req stays high across back-to-back squash reissues. A new request is implied by the address change after an ack.
- HOLD:
  - imem_req=0, inst_valid=1. inst_out and inst_pc are held stable until accepted.
  - inst_ready=1, no redirect: transfer occurs; inst_valid<=0, state<=REQ.
  - redirect_valid=1, with or without inst_ready: inst_valid<=0, pc<=redirect_pc, state<=REQ.
    - If inst_ready was also 1, the transfer is counted as completed.
    - Otherwise the held instruction is dropped.
- Throughput: one fetch, then at least one HOLD cycle. Maximum rate is 1 instruction per 2 cycles; no prefetch.
- Reset mid-operation: immediate return to reset values. Any outstanding memory request is abandoned; memory must tolerate imem_req dropping.
- imem_ack outside REQ is ignored.

Test Plan:
- Reset release with imem_ack tied 1, inst_ready tied 1 -> imem_addr sequence 0,4,8,C. inst_valid pulses every 2nd cycle with matching inst_pc. pc_out tracks +4.
- 3-cycle memory latency, inst_ready=1 -> imem_addr held at 0x8 for 3 REQ cycles. inst_out=rdata at the ack. No duplicate inst_valid.
- Redirect to 0x100 during the 2nd wait cycle of a fetch at 0x8 -> the 0x8 data is discarded (no inst_valid). The next request is at 0x100, and the delivered inst_pc is 0x100.
- Redirects 0x100 then 0x200 during one outstanding fetch -> a single reissue, at 0x200.
- inst_ready=0 for 4 cycles in HOLD -> inst_out/inst_pc stable, imem_req=0. Redirect to 0x40 in HOLD -> instruction dropped, next fetch at 0x40.
- Redirect to 0xFFFF_FFFC -> next fetch there, then pc wraps to 0x0. Assert rst mid-REQ -> imem_req=0 and pc=RESET_PC immediately.
